// File: rtl/fir_pkg.sv
// fir_pkg: state encoding, default widths and mode constants shared by the FIR address generator
package fir_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} fir_state_t;
   localparam int AW_P_D = 13;
   localparam int AW_W_D = 8;
   localparam int CW_D = 15;
   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_CONT = 1'b1;
endpackage

// File: rtl/fir_idx_counter.sv
// fir_idx_counter: up counter 0..max with clear, enable and a wrap strobe; exposes its next value
module fir_idx_counter #(
   parameter int W = 8
) (
   input  logic         clk_b,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] max,
   output logic [W-1:0] cnt,
   output logic [W-1:0] nxt,
   output logic         wrap
);
   assign wrap = en & (cnt == max);
   assign nxt = clr ? '0 : wrap ? '0 : en ? cnt + 1'b1 : cnt;
   always_ff @(posedge clk_b or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= nxt;
endmodule

// File: rtl/fir_conv_addr_gen.sv
// fir_conv_addr_gen: nested n/k counters issuing sample address n-k and coefficient address k
module fir_conv_addr_gen
   import fir_pkg::*;
#(
   parameter int AW_P = AW_P_D,
   parameter int AW_W = AW_W_D,
   parameter int CW = CW_D
) (
   input  logic            clk_b,
   input  logic            rst_n,
   input  logic            cfg_load,
   input  logic [CW-1:0]   cfg_ile_probek,
   input  logic [AW_W:0]   cfg_ile_wsp,
   input  logic            cfg_tryb,
   input  logic            start,
   input  logic            abort,
   input  logic            addr_ready,
   output logic            addr_valid,
   output logic [AW_P-1:0] a_probki,
   output logic [AW_W-1:0] a_wsp,
   output logic            probka_valid,
   output logic            mac_first,
   output logic            mac_last,
   output logic [CW-1:0]   wynik_idx,
   output logic            busy,
   output logic            done,
   output logic            cfg_err
);
   fir_state_t state, st_nxt;
   logic [CW-1:0] p_r, r_r, n_nxt;
   logic [AW_W:0] t_r;
   logic [AW_W-1:0] k_max, k_nxt;
   logic [CW:0] s_nxt;
   logic tryb_r, cfg_vld, cfg_bad, xfer, k_wrap, n_wrap, go_idle, go_done, av_nxt, pv_nxt;
   assign cfg_bad = (cfg_ile_probek == '0) | (cfg_ile_wsp == '0) |
                    (cfg_ile_probek > CW'(2 ** AW_P)) | (cfg_ile_wsp[AW_W] & |cfg_ile_wsp[AW_W-1:0]);
   assign k_max = AW_W'(t_r - 1'b1);
   assign xfer = addr_valid & addr_ready;
   assign go_idle = (state == IDLE) & start & cfg_vld & !abort;
   assign go_done = (state == DONE) & (tryb_r == MODE_CONT) & !abort;
   assign av_nxt = go_idle | go_done | ((state == RUN) & !abort & !n_wrap);
   assign st_nxt = abort ? IDLE : (go_idle | go_done) ? RUN :
                   (state == RUN) ? (n_wrap ? DONE : RUN) : IDLE;
   fir_idx_counter #(.W(AW_W)) u_k (
      .clk_b(clk_b), .rst_n(rst_n), .en(xfer), .clr(go_idle | go_done | abort),
      .max(k_max), .cnt(a_wsp), .nxt(k_nxt), .wrap(k_wrap)
   );
   fir_idx_counter #(.W(CW)) u_n (
      .clk_b(clk_b), .rst_n(rst_n), .en(k_wrap), .clr(go_idle | go_done | abort),
      .max(r_r - CW'(1)), .cnt(wynik_idx), .nxt(n_nxt), .wrap(n_wrap)
   );
   // Beat flags are registered from the counters' next values so they line up with a_wsp/wynik_idx
   assign s_nxt = {1'b0, n_nxt} - (CW + 1)'(k_nxt);
   assign pv_nxt = !s_nxt[CW] & (s_nxt[CW-1:0] < p_r);
   always_ff @(posedge clk_b or negedge rst_n)
      if (!rst_n) begin
         p_r <= '0;
         t_r <= '0;
         r_r <= '0;
         tryb_r <= MODE_ONESHOT;
         cfg_err <= 1'b0;
         cfg_vld <= 1'b0;
      end else if (cfg_load && state == IDLE) begin
         p_r <= cfg_ile_probek;
         t_r <= cfg_ile_wsp;
         r_r <= cfg_ile_probek + CW'(cfg_ile_wsp) - CW'(1);
         tryb_r <= cfg_tryb;
         cfg_err <= cfg_bad;
         cfg_vld <= !cfg_bad;
      end
   always_ff @(posedge clk_b or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         addr_valid <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         a_probki <= '0;
         probka_valid <= 1'b0;
         mac_first <= 1'b0;
         mac_last <= 1'b0;
      end else begin
         state <= st_nxt;
         addr_valid <= av_nxt;
         busy <= st_nxt != IDLE;
         done <= (state == RUN) & n_wrap & !abort;
         a_probki <= (av_nxt & pv_nxt) ? s_nxt[AW_P-1:0] : '0;
         probka_valid <= av_nxt & pv_nxt;
         mac_first <= av_nxt & (k_nxt == '0);
         mac_last <= av_nxt & (k_nxt == k_max);
      end
endmodule
